sdram_icache: RTL and testbench

- Direct-mapped, read-only instruction cache between the CPU fetch stage and the SDRAM controller's CPU-side port.
- Hits return a 32-bit instruction one cycle after the request.
- Misses issue one instruction-mode read (two pipelined 16-bit SDRAM reads, returned as one 32-bit word), fill the line and forward the word to fetch.
- Runs entirely in the CPU clock domain, the same clock that drives the controller's request side.

---
 rtl/sdram_icache_pkg.sv | 14 +
 rtl/sdram_icache_tagram.sv | 47 ++++
 rtl/sdram_icache.sv | 145 ++++++++++++++
 tb/tb_sdram_icache.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_icache_pkg.sv
// Shared definitions for the SDRAM instruction cache: FSM encoding and controller constants.
package sdram_icache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StAck,
    StData
  } state_e;

  localparam int unsigned AckTimeout = 4;
  localparam int unsigned SdramAddrW = 23;

endpackage

// File: rtl/sdram_icache_tagram.sv
// Valid/tag/data line array: combinational read port, one write port, synchronous flush-all.
module sdram_icache_tagram #(
  parameter int unsigned IdxW = 6,
  parameter int unsigned TagW = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic [IdxW-1:0] i_rd_idx,
  output logic            o_rd_valid,
  output logic [TagW-1:0] o_rd_tag,
  output logic [31:0]     o_rd_data,
  input  logic            i_wr_en,
  input  logic [IdxW-1:0] i_wr_idx,
  input  logic            i_wr_valid,
  input  logic [TagW-1:0] i_wr_tag,
  input  logic [31:0]     i_wr_data
);

  localparam int unsigned Depth = 1 << IdxW;

  logic [Depth-1:0] r_valid;
  logic [TagW-1:0]  r_tag  [Depth];
  logic [31:0]      r_data [Depth];

  // A flush landing on the fill edge wins over the fill's valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      if (i_flush) r_valid <= '0;
      if (i_wr_en) r_valid[i_wr_idx] <= i_wr_valid & ~i_flush;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/sdram_icache.sv
// Direct-mapped read-only instruction cache in front of the SDRAM controller's CPU port.
module sdram_icache
  import sdram_icache_pkg::*;
#(
  parameter int unsigned IDX_W   = 6,
  parameter int unsigned IADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IADDR_W-1:0]    f_addr,
  input  logic                  f_req,
  output logic                  f_busy,
  output logic                  f_valid,
  output logic [31:0]           f_data,
  input  logic                  flush,
  output logic [SdramAddrW-1:0] m_addr,
  output logic                  m_read_req,
  output logic                  m_instr_mode,
  input  logic                  m_busy,
  input  logic                  m_cack,
  input  logic                  m_read_ready,
  input  logic [31:0]           m_data,
  output logic [15:0]           hit_cnt,
  output logic [15:0]           miss_cnt
);

  localparam int unsigned TagW = IADDR_W - IDX_W;

  state_e                r_state;
  logic [IADDR_W-1:0]    r_addr;
  logic                  r_flushed;
  logic [2:0]            r_ack_cnt;
  logic                  r_f_busy;
  logic                  r_f_valid;
  logic [31:0]           r_f_data;
  logic                  r_m_read_req;
  logic [SdramAddrW-1:0] r_m_addr;
  logic [15:0]           r_hit_cnt;
  logic [15:0]           r_miss_cnt;

  logic                  w_rd_valid;
  logic [TagW-1:0]       w_rd_tag;
  logic [31:0]           w_rd_data;
  logic                  w_hit;
  logic                  w_fill;
  logic [SdramAddrW-1:0] w_addr_ext;

  // A flush on the lookup edge forces a miss even if the line was valid.
  assign w_hit      = w_rd_valid && (w_rd_tag == f_addr[IADDR_W-1:IDX_W]) && !flush;
  assign w_fill     = (r_state == StData) && m_read_ready && !rst;
  assign w_addr_ext = {{(SdramAddrW - IADDR_W){1'b0}}, f_addr};

  sdram_icache_tagram #(
    .IdxW (IDX_W),
    .TagW (TagW)
  ) u_tagram (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (flush),
    .i_rd_idx   (f_addr[IDX_W-1:0]),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_wr_en    (w_fill),
    .i_wr_idx   (r_addr[IDX_W-1:0]),
    .i_wr_valid (~r_flushed),
    .i_wr_tag   (r_addr[IADDR_W-1:IDX_W]),
    .i_wr_data  (m_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_flushed    <= 1'b0;
      r_ack_cnt    <= '0;
      r_f_busy     <= 1'b0;
      r_f_valid    <= 1'b0;
      r_f_data     <= '0;
      r_m_read_req <= 1'b0;
      r_m_addr     <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      r_f_valid <= 1'b0;
      if (flush && (r_state != StIdle)) r_flushed <= 1'b1;
      unique case (r_state)
        StIdle: begin
          if (f_req) begin
            if (w_hit) begin
              r_f_valid <= 1'b1;
              r_f_data  <= w_rd_data;
              if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
            end else begin
              r_addr       <= f_addr;
              r_m_addr     <= w_addr_ext;
              r_m_read_req <= 1'b1;
              r_f_busy     <= 1'b1;
              r_flushed    <= 1'b0;
              if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
              r_state      <= StReq;
            end
          end
        end
        StReq: begin
          if (!m_busy) begin
            r_m_read_req <= 1'b0;
            r_ack_cnt    <= '0;
            r_state      <= StAck;
          end
        end
        StAck: begin
          // Read-ready seen here belongs to an older transfer and is ignored.
          if (m_cack) begin
            r_state <= StData;
          end else if (r_ack_cnt == 3'(AckTimeout - 1)) begin
            r_m_read_req <= 1'b1;
            r_state      <= StReq;
          end else begin
            r_ack_cnt <= r_ack_cnt + 3'd1;
          end
        end
        StData: begin
          if (m_read_ready) begin
            r_f_data  <= m_data;
            r_f_valid <= 1'b1;
            r_f_busy  <= 1'b0;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign f_busy       = r_f_busy;
  assign f_valid      = r_f_valid;
  assign f_data       = r_f_data;
  assign m_read_req   = r_m_read_req;
  assign m_addr       = r_m_addr;
  assign m_instr_mode = 1'b1;
  assign hit_cnt      = r_hit_cnt;
  assign miss_cnt     = r_miss_cnt;

endmodule

// File: tb/tb_sdram_icache.sv
// Randomized bench for sdram_icache with a protocol-level cache model and a modelled controller.
module tb_sdram_icache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] f_addr = '0;
  logic        f_req = 1'b0;
  logic        f_busy, f_valid;
  logic [31:0] f_data;
  logic        flush = 1'b0;
  logic [22:0] m_addr;
  logic        m_read_req, m_instr_mode;
  logic        m_busy = 1'b0, m_cack = 1'b0, m_read_ready = 1'b0;
  logic [31:0] m_data = '0;
  logic [15:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  sdram_icache #(
    .IDX_W   (6),
    .IADDR_W (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .f_addr       (f_addr),
    .f_req        (f_req),
    .f_busy       (f_busy),
    .f_valid      (f_valid),
    .f_data       (f_data),
    .flush        (flush),
    .m_addr       (m_addr),
    .m_read_req   (m_read_req),
    .m_instr_mode (m_instr_mode),
    .m_busy       (m_busy),
    .m_cack       (m_cack),
    .m_read_ready (m_read_ready),
    .m_data       (m_data)
    ,.hit_cnt     (hit_cnt),
    .miss_cnt     (miss_cnt)
  );

  int checks = 0;
  int errors = 0;
  bit started = 0;
  logic [31:0] mem [0:65535];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the cache remembers which full addresses are resident; a miss is one
  // outstanding controller read whose data is whatever the bench memory holds.
  logic        mp_pend, mp_cacked, mp_flushed;
  int          mp_wait;
  logic [15:0] mp_addr;
  logic [63:0] c_valid;
  logic [15:0] c_addr [64];
  logic        e_fvalid, e_busy, e_req;
  logic [31:0] e_fdata;
  logic [22:0] e_maddr;
  int          e_hits, e_misses;

  always @(posedge clk) begin : model
    int idx;
    if (rst) begin
      mp_pend = 0; mp_cacked = 0; mp_flushed = 0; mp_wait = 0; c_valid = '0;
      e_fvalid = 0; e_fdata = '0; e_busy = 0; e_req = 0; e_maddr = '0;
      e_hits = 0; e_misses = 0;
    end else begin
      e_fvalid = 0;
      if (!mp_pend) begin
        idx = int'(f_addr[5:0]);
        if (f_req && !flush && c_valid[idx] && c_addr[idx] == f_addr) begin
          e_fvalid = 1; e_fdata = mem[f_addr];
          if (e_hits < 65535) e_hits++;
        end else if (f_req) begin
          mp_pend = 1; mp_addr = f_addr; mp_cacked = 0; mp_flushed = 0; mp_wait = 0;
          e_req = 1; e_busy = 1; e_maddr = {7'd0, f_addr};
          if (e_misses < 65535) e_misses++;
        end
        if (flush) c_valid = '0;
      end else begin
        if (flush) begin c_valid = '0; mp_flushed = 1; end
        if (e_req) begin
          if (!m_busy) begin e_req = 0; mp_wait = 0; mp_cacked = 0; end
        end else if (!mp_cacked) begin
          if (m_cack) mp_cacked = 1;
          else begin
            mp_wait++;
            if (mp_wait == 4) e_req = 1;
          end
        end else if (m_read_ready) begin
          idx = int'(mp_addr[5:0]);
          if (!mp_flushed) begin c_valid[idx] = 1; c_addr[idx] = mp_addr; end
          e_fvalid = 1; e_fdata = mem[mp_addr]; e_busy = 0; mp_pend = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("f_valid", 32'(f_valid), 32'(e_fvalid));
      if (e_fvalid) chk("f_data", f_data, e_fdata);
      chk("f_busy", 32'(f_busy), 32'(e_busy));
      chk("m_read_req", 32'(m_read_req), 32'(e_req));
      chk("m_addr", 32'(m_addr), 32'(e_maddr));
      chk("m_instr_mode", 32'(m_instr_mode), 32'd1);
      chk("hit_cnt", 32'(hit_cnt), 32'(e_hits));
      chk("miss_cnt", 32'(miss_cnt), 32'(e_misses));
    end
  end

  // Controller model state
  bit          rand_mode = 0;
  int          busy_force = 0;
  int          fix_cack = 2, fix_rdy = 3;
  bit          c_act = 0, c_drop = 0, c_junk = 0;
  int          c_t = 0, c_cd = 1, c_rd = 1;
  logic [22:0] c_addr_l = '0;
  logic        prev_req = 0, prev_busy = 0;
  logic [22:0] prev_addr = '0;
  int          acc_count = 0;
  logic [22:0] acc_addr = '0;

  task automatic step();
    bit acc;
    @(posedge clk);
    #1;
    acc = prev_req && !prev_busy && !rst;
    if (acc) begin
      acc_count++; acc_addr = prev_addr; c_addr_l = prev_addr; c_act = 1; c_t = 0;
      if (rand_mode) begin
        c_drop = ($urandom % 8 == 0); c_cd = 1 + int'($urandom % 3);
        c_rd = 1 + int'($urandom % 4); c_junk = $urandom % 2 == 1;
      end else begin
        c_drop = 0; c_cd = fix_cack; c_rd = fix_rdy; c_junk = 0;
      end
    end else if (c_act) begin
      c_t++;
    end
    m_cack = 0; m_read_ready = 0; m_data = $urandom;
    if (c_act) begin
      if (!c_drop && c_t + 1 == c_cd) m_cack = 1;
      if (!c_drop && c_t + 1 == c_cd + c_rd) begin
        m_read_ready = 1; m_data = mem[c_addr_l[15:0]]; c_act = 0;
      end else if (c_junk && c_t + 1 <= c_cd) begin
        m_read_ready = 1;
      end
      if (c_drop && c_t + 1 >= 4) c_act = 0;
    end else if (rand_mode && $urandom % 6 == 0) begin
      m_read_ready = 1;
    end
    if (busy_force > 0) begin m_busy = 1; busy_force--; end
    else m_busy = rand_mode && ($urandom % 3 == 0);
    prev_req = m_read_req; prev_busy = m_busy; prev_addr = m_addr;
  endtask

  task automatic fetch(input logic [15:0] a, input int fs, output logic [31:0] d, output int lat);
    bit got = 0;
    d = '0;
    f_req = 1; f_addr = a; flush = (fs == 0);
    step();
    lat = 1; f_req = 0; flush = 0;
    while (!got && lat < 60) begin
      if (f_valid) got = 1;
      else begin
        flush = (lat == fs); step(); flush = 0; lat++;
      end
    end
    if (got) d = f_data;
    chk("fetch_done", 32'(got), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    int lat;
    bit saw;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    mem[16'h0040] = 32'hDEADBEEF;
    mem[16'h0080] = 32'h0BADF00D;
    mem[16'h02C5] = 32'h12345678;

    rst = 1; step(); step(); rst = 0;
    started = 1;
    chk("rst_f_valid", 32'(f_valid), 32'd0);
    chk("rst_f_data", f_data, 32'd0);
    chk("rst_f_busy", 32'(f_busy), 32'd0);
    chk("rst_m_read_req", 32'(m_read_req), 32'd0);
    chk("rst_m_addr", 32'(m_addr), 32'd0);
    chk("rst_cnts", {hit_cnt, miss_cnt}, 32'd0);

    acc_count = 0;
    fetch(16'h0040, -1, d, lat);
    chk("cold_data", d, 32'hDEADBEEF);
    chk("cold_lat", 32'(lat), 32'd7);
    chk("cold_acc", 32'(acc_count), 32'd1);
    chk("cold_maddr", 32'(acc_addr), 32'h40);
    chk("cold_miss", 32'(miss_cnt), 32'd1);

    fetch(16'h0040, -1, d, lat);
    chk("hit_data", d, 32'hDEADBEEF);
    chk("hit_lat", 32'(lat), 32'd1);
    chk("hit_acc", 32'(acc_count), 32'd1);
    chk("hit_cnt1", 32'(hit_cnt), 32'd1);

    fetch(16'h0080, -1, d, lat);
    chk("conf_a_data", d, 32'h0BADF00D);
    fetch(16'h0040, -1, d, lat);
    chk("conf_b_data", d, 32'hDEADBEEF);
    chk("conf_b_lat", 32'(lat), 32'd7);
    chk("conf_acc", 32'(acc_count), 32'd3);

    fetch(16'h0040, 0, d, lat);
    chk("flush_idle_lat", 32'(lat), 32'd7);
    fetch(16'h0040, -1, d, lat);
    chk("refill_hit_lat", 32'(lat), 32'd1);

    busy_force = 10;
    fetch(16'h01C0, -1, d, lat);
    chk("busy_lat", 32'(lat), 32'd17);
    chk("busy_maddr", 32'(acc_addr), 32'h1C0);
    chk("busy_acc", 32'(acc_count), 32'd5);

    fetch(16'h02C5, 4, d, lat);
    chk("flush_data_fwd", d, 32'h12345678);
    fetch(16'h02C5, -1, d, lat);
    chk("flush_data_remiss", 32'(lat), 32'd7);
    chk("cnts_mid", {hit_cnt, miss_cnt}, {16'd2, 16'd7});

    f_req = 1; f_addr = 16'h0300; step(); f_req = 0;
    repeat (3) step();
    rst = 1; step(); rst = 0;
    saw = 0;
    repeat (8) begin step(); if (f_valid) saw = 1; end
    chk("rst_fill_no_valid", 32'(saw), 32'd0);
    chk("rst_fill_busy", 32'(f_busy), 32'd0);
    chk("rst_fill_cnts", {hit_cnt, miss_cnt}, 32'd0);
    fetch(16'h0300, -1, d, lat);
    chk("rst_fill_remiss", 32'(lat), 32'd7);
    chk("rst_fill_miss", 32'(miss_cnt), 32'd1);

    rand_mode = 1;
    repeat (3000) begin
      step();
      f_req  = ($urandom % 3 != 0);
      f_addr = 16'((($urandom % 4) << 6) | ($urandom % 8));
      flush  = ($urandom % 25 == 0);
    end
    f_req = 0; flush = 0; rand_mode = 0;
    repeat (40) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
